k12a_spi_target: RTL and testbench

SPI target (responder) peripheral, mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames. Lets a k12a system be driven by an external SPI initiator. Oversamples the external SCK/SS_n/MOSI with the system clock and shifts bytes in and out. Exposes an RX buffer, a TX buffer and a status register on the shared data bus through decoded IO strobes.

---
 rtl/k12a_spi_target_pkg.sv | 17 +
 rtl/k12a_spi_target_if.sv | 26 ++
 rtl/k12a_spi_target_sync_edge.sv | 44 ++++
 rtl/k12a_spi_target.sv | 175 +++++++++++++++++
 tb/tb_k12a_spi_target.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/k12a_spi_target_pkg.sv
// k12a_spi_target_pkg
// Shared types and constants for the k12a SPI target peripheral.
//   spi_target_state_t      : transfer FSM states (IDLE / SHIFT)
//   SPI_TARGET_STAT_*       : bit positions inside the status byte
package k12a_spi_target_pkg;

    typedef enum logic {
        SPI_TARGET_STATE_IDLE  = 1'b0,
        SPI_TARGET_STATE_SHIFT = 1'b1
    } spi_target_state_t;

    localparam int SPI_TARGET_STAT_RX_FULL  = 0;
    localparam int SPI_TARGET_STAT_TX_EMPTY = 1;
    localparam int SPI_TARGET_STAT_OVERRUN  = 2;
    localparam int SPI_TARGET_STAT_ACTIVE   = 3;

endpackage

// File: rtl/k12a_spi_target_if.sv
// k12a_spi_target_if
// Decoded IO strobes from the k12a CPU to the SPI target.
//   spi_data_io_load   : CPU reads rx_buf (clears rx_full)
//   spi_data_io_store  : CPU writes tx_buf (clears tx_empty)
//   spi_status_io_load : CPU reads the status byte (clears overrun)
// master = CPU side (drives strobes), slave = peripheral side.
// The 8-bit shared data bus stays a plain inout port on the peripheral.
interface k12a_spi_target_if;

    logic spi_data_io_load;
    logic spi_data_io_store;
    logic spi_status_io_load;

    modport master (
        output spi_data_io_load,
        output spi_data_io_store,
        output spi_status_io_load
    );

    modport slave (
        input spi_data_io_load,
        input spi_data_io_store,
        input spi_status_io_load
    );

endinterface

// File: rtl/k12a_spi_target_sync_edge.sv
// k12a_sync_edge
// Synchronises one asynchronous input through STAGES flops, then keeps one
// history flop so edges can be detected on the synchronised level.
//   clock, reset_n : system clock, async active-low reset
//   async_in       : external asynchronous input
//   level          : synchronised level (last sync stage)
//   rise / fall    : single-cycle pulses on synchronised edges
// Parameters: STAGES (>= 2), RESET_LEVEL (idle level of the input).
module k12a_sync_edge #(
    parameter int   STAGES      = 2,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              hist_q, hist_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_in};
        hist_d = sync_q[STAGES-1];
    end

    // Reset to the idle level so no spurious edge appears after reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {STAGES{RESET_LEVEL}};
            hist_q <= RESET_LEVEL;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;

endmodule

// File: rtl/k12a_spi_target.sv
// k12a_spi_target
// SPI target, mode 0, MSB first, 8-bit frames. External SCK/SS_n/MOSI are
// oversampled by the system clock; received bytes land in rx_buf, bytes to
// send are queued in tx_buf.
// Ports:
//   clock, reset_n        : system clock, async active-low reset
//   cpu_if (slave)        : data load / data store / status load strobes
//   data_bus              : shared 8-bit bus, driven only during a load strobe
//   spi_ss_n, spi_sck,
//   spi_mosi              : external SPI inputs (asynchronous)
//   spi_miso, spi_miso_oe : MISO data and output enable
//   spi_irq               : interrupt, only live with K12A_SPI_TARGET_IRQ_EN
// Status byte: {4'b0, active, overrun, tx_empty, rx_full}.
// Optional macro: K12A_SPI_TARGET_IRQ_EN enables the registered interrupt.
module k12a_spi_target
    import k12a_spi_target_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_FILL   = 8'hFF
) (
    input  logic               clock,
    input  logic               reset_n,
    k12a_spi_target_if.slave   cpu_if,
    inout  wire  [7:0]         data_bus,
    input  logic               spi_ss_n,
    input  logic               spi_sck,
    input  logic               spi_mosi,
    output logic               spi_miso,
    output logic               spi_miso_oe,
    output logic               spi_irq
);

    logic sck_level, sck_rise, sck_fall;
    logic ss_level, ss_rise, ss_fall;
    logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

    // All three inputs share the same depth so MOSI stays aligned with SCK.
    k12a_sync_edge #(.STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sync_sck (
        .clock(clock), .reset_n(reset_n), .async_in(spi_sck),
        .level(sck_level), .rise(sck_rise), .fall(sck_fall)
    );

    k12a_sync_edge #(.STAGES(SYNC_STAGES), .RESET_LEVEL(1'b1)) u_sync_ss (
        .clock(clock), .reset_n(reset_n), .async_in(spi_ss_n),
        .level(ss_level), .rise(ss_rise), .fall(ss_fall)
    );

    k12a_sync_edge #(.STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_sync_mosi (
        .clock(clock), .reset_n(reset_n), .async_in(spi_mosi),
        .level(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_target_state_t state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_reg_q, shift_reg_d;
    logic [7:0] rx_buf_q, rx_buf_d;
    logic [7:0] tx_buf_q, tx_buf_d;
    logic       rx_full_q, rx_full_d;
    logic       tx_empty_q, tx_empty_d;
    logic       overrun_q, overrun_d;
    logic       active;
    logic [7:0] status;
    logic [7:0] shift_in;
    logic [7:0] reload_val;

    assign active     = (state_q == SPI_TARGET_STATE_SHIFT);
    assign shift_in   = {shift_reg_q[6:0], mosi_sync};
    assign reload_val = tx_empty_q ? IDLE_FILL : tx_buf_q;

    always_comb begin
        status = 8'h00;
        status[SPI_TARGET_STAT_RX_FULL]  = rx_full_q;
        status[SPI_TARGET_STAT_TX_EMPTY] = tx_empty_q;
        status[SPI_TARGET_STAT_OVERRUN]  = overrun_q;
        status[SPI_TARGET_STAT_ACTIVE]   = active;
    end

    // CPU clears are applied first so that flag sets from the shifter later
    // in this block win; the TX store is applied last so it wins tx_empty
    // over a simultaneous reload (which still consumes the old tx_buf).
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_reg_d = shift_reg_q;
        rx_buf_d    = rx_buf_q;
        tx_buf_d    = tx_buf_q;
        rx_full_d   = rx_full_q;
        tx_empty_d  = tx_empty_q;
        overrun_d   = overrun_q;

        if (cpu_if.spi_data_io_load)   rx_full_d = 1'b0;
        if (cpu_if.spi_status_io_load) overrun_d = 1'b0;
        if (cpu_if.spi_data_io_store)  tx_buf_d  = data_bus;

        case (state_q)
            SPI_TARGET_STATE_IDLE: begin
                if (ss_fall) begin
                    state_d     = SPI_TARGET_STATE_SHIFT;
                    bit_cnt_d   = 3'd0;
                    shift_reg_d = reload_val;
                    tx_empty_d  = 1'b1;
                end
            end
            SPI_TARGET_STATE_SHIFT: begin
                if (ss_rise) begin
                    // Partial byte is dropped without touching any flag.
                    state_d     = SPI_TARGET_STATE_IDLE;
                    bit_cnt_d   = 3'd0;
                    shift_reg_d = IDLE_FILL;
                end else if (sck_rise) begin
                    shift_reg_d = shift_in;
                    bit_cnt_d   = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_buf_d  = shift_in;
                        rx_full_d = 1'b1;
                        if (rx_full_q && !cpu_if.spi_data_io_load) overrun_d = 1'b1;
                    end
                end else if (sck_fall && bit_cnt_q == 3'd0) begin
                    shift_reg_d = reload_val;
                    tx_empty_d  = 1'b1;
                end
            end
            default: state_d = SPI_TARGET_STATE_IDLE;
        endcase

        if (cpu_if.spi_data_io_store) tx_empty_d = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= SPI_TARGET_STATE_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_reg_q <= IDLE_FILL;
            rx_buf_q    <= 8'h00;
            tx_buf_q    <= 8'h00;
            rx_full_q   <= 1'b0;
            tx_empty_q  <= 1'b1;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_reg_q <= shift_reg_d;
            rx_buf_q    <= rx_buf_d;
            tx_buf_q    <= tx_buf_d;
            rx_full_q   <= rx_full_d;
            tx_empty_q  <= tx_empty_d;
            overrun_q   <= overrun_d;
        end
    end

    // Data load has priority if software ever raises both load strobes.
    assign data_bus = cpu_if.spi_data_io_load   ? rx_buf_q :
                      cpu_if.spi_status_io_load ? status   : 8'hzz;

    assign spi_miso    = shift_reg_q[7];
    assign spi_miso_oe = ~ss_level;

`ifdef K12A_SPI_TARGET_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = rx_full_q | overrun_q | (tx_empty_q & active);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) irq_q <= 1'b0;
        else          irq_q <= irq_d;
    end

    assign spi_irq = irq_q;
`else
    assign spi_irq = 1'b0;
`endif

endmodule

// File: tb/tb_k12a_spi_target.sv
// tb_k12a_spi_target
// Directed bench for k12a_spi_target: acts as both the k12a CPU (IO strobes
// on the shared bus) and an external mode-0 SPI initiator with 10 system
// clocks per SCK phase. Expected values are hand-computed constants.
// Interrupt expectations follow K12A_SPI_TARGET_IRQ_EN.
module tb_k12a_spi_target;

    localparam int SYNC_STAGES = 2;
    localparam int PHASE       = 10;
`ifdef K12A_SPI_TARGET_IRQ_EN
    localparam logic [7:0] IRQ_ON = 8'h01;
`else
    localparam logic [7:0] IRQ_ON = 8'h00;
`endif

    logic       clock;
    logic       reset_n;
    logic       spi_ss_n, spi_sck, spi_mosi;
    logic       spi_miso, spi_miso_oe, spi_irq;
    logic       tb_drive;
    logic [7:0] tb_data;
    wire  [7:0] data_bus;

    int checks = 0;
    int errors = 0;

    k12a_spi_target_if cpu_if ();

    assign data_bus = tb_drive ? tb_data : 8'hzz;

    k12a_spi_target #(.SYNC_STAGES(SYNC_STAGES), .IDLE_FILL(8'hFF)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cpu_if      (cpu_if.slave),
        .data_bus    (data_bus),
        .spi_ss_n    (spi_ss_n),
        .spi_sck     (spi_sck),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .spi_irq     (spi_irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %02h, expected %02h", tag, actual, expected);
        end
    endtask

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic writeTx(input logic [7:0] value);
        @(negedge clock);
        tb_drive = 1'b1;
        tb_data  = value;
        cpu_if.spi_data_io_store = 1'b1;
        @(negedge clock);
        cpu_if.spi_data_io_store = 1'b0;
        tb_drive = 1'b0;
    endtask

    task automatic readData(output logic [7:0] value);
        @(negedge clock);
        cpu_if.spi_data_io_load = 1'b1;
        #1 value = data_bus;
        @(negedge clock);
        cpu_if.spi_data_io_load = 1'b0;
    endtask

    task automatic readStatus(output logic [7:0] value);
        @(negedge clock);
        cpu_if.spi_status_io_load = 1'b1;
        #1 value = data_bus;
        @(negedge clock);
        cpu_if.spi_status_io_load = 1'b0;
    endtask

    task automatic spiSelect();
        @(negedge clock);
        spi_ss_n = 1'b0;
        waitClocks(PHASE);
    endtask

    task automatic spiDeselect();
        waitClocks(PHASE);
        spi_ss_n = 1'b1;
        waitClocks(PHASE);
    endtask

    // One SCK period: MOSI set while SCK low, MISO sampled just before rise.
    task automatic applyStimulus(input logic mosi_bit, output logic miso_bit);
        spi_mosi = mosi_bit;
        waitClocks(PHASE);
        miso_bit = spi_miso;
        spi_sck  = 1'b1;
        waitClocks(PHASE);
        spi_sck  = 1'b0;
    endtask

    task automatic sendFrame(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) applyStimulus(tx[i], rx[i]);
    endtask

    logic [7:0] val;
    logic [7:0] miso_byte;
    logic       bit_out;

    initial begin
        reset_n  = 1'b0;
        spi_ss_n = 1'b1;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        tb_drive = 1'b0;
        tb_data  = 8'h00;
        cpu_if.spi_data_io_load   = 1'b0;
        cpu_if.spi_data_io_store  = 1'b0;
        cpu_if.spi_status_io_load = 1'b0;
        waitClocks(3);
        reset_n = 1'b1;
        waitClocks(2);

        // Reset state
        checkOutput("reset_miso_oe", {7'd0, spi_miso_oe}, 8'h00);
        checkOutput("reset_miso", {7'd0, spi_miso}, 8'h01);
        checkOutput("reset_irq", {7'd0, spi_irq}, 8'h00);
        readStatus(val);  checkOutput("reset_status", val, 8'h02);
        readData(val);    checkOutput("reset_rx_buf", val, 8'h00);

        // Queued TX byte A5 while receiving 3C
        writeTx(8'hA5);
        readStatus(val);  checkOutput("t1_status_queued", val, 8'h00);
        spiSelect();
        checkOutput("t1_miso_oe", {7'd0, spi_miso_oe}, 8'h01);
        sendFrame(8'h3C, miso_byte);
        checkOutput("t1_miso_bits", miso_byte, 8'hA5);
        waitClocks(PHASE);
        readStatus(val);  checkOutput("t1_status_active", val, 8'h0B);
        checkOutput("t1_irq_set", {7'd0, spi_irq}, IRQ_ON);
        spiDeselect();
        readStatus(val);  checkOutput("t1_status_idle", val, 8'h03);
        readData(val);    checkOutput("t1_rx_buf", val, 8'h3C);
        waitClocks(3);
        checkOutput("t1_irq_clear", {7'd0, spi_irq}, 8'h00);
        readStatus(val);  checkOutput("t1_status_read", val, 8'h02);

        // Two back-to-back bytes, no TX, no reads -> overrun
        spiSelect();
        sendFrame(8'h01, miso_byte);
        checkOutput("t2_miso_byte0", miso_byte, 8'hFF);
        sendFrame(8'h02, miso_byte);
        checkOutput("t2_miso_byte1", miso_byte, 8'hFF);
        spiDeselect();
        readStatus(val);  checkOutput("t2_status_overrun", val, 8'h07);
        readStatus(val);  checkOutput("t2_status_cleared", val, 8'h03);
        readData(val);    checkOutput("t2_rx_buf", val, 8'h02);

        // Partial frame discarded, then full frame C3
        spiSelect();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, bit_out);
        spiDeselect();
        readStatus(val);  checkOutput("t3_status_partial", val, 8'h02);
        spiSelect();
        sendFrame(8'hC3, miso_byte);
        spiDeselect();
        readStatus(val);  checkOutput("t3_status_full", val, 8'h03);
        readData(val);    checkOutput("t3_rx_buf", val, 8'hC3);

        // Data load on the exact completion cycle
        spiSelect();
        sendFrame(8'h11, miso_byte);
        spiDeselect();
        spiSelect();
        for (int i = 7; i >= 1; i--) applyStimulus(((8'h22 >> i) & 8'h01) != 8'h00, bit_out);
        spi_mosi = 1'b0;
        waitClocks(PHASE);
        spi_sck = 1'b1;
        waitClocks(SYNC_STAGES);
        cpu_if.spi_data_io_load = 1'b1;
        #1 val = data_bus;
        @(negedge clock);
        cpu_if.spi_data_io_load = 1'b0;
        checkOutput("t4_bus_old", val, 8'h11);
        waitClocks(PHASE - SYNC_STAGES - 1);
        spi_sck = 1'b0;
        spiDeselect();
        readStatus(val);  checkOutput("t4_status", val, 8'h03);
        readData(val);    checkOutput("t4_rx_buf", val, 8'h22);

        // Async reset during bit 4, then a clean frame
        writeTx(8'h96);
        spiSelect();
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, bit_out);
        spi_sck = 1'b1;
        waitClocks(3);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("t5_rst_miso_oe", {7'd0, spi_miso_oe}, 8'h00);
        checkOutput("t5_rst_miso", {7'd0, spi_miso}, 8'h01);
        checkOutput("t5_rst_irq", {7'd0, spi_irq}, 8'h00);
        spi_sck  = 1'b0;
        spi_ss_n = 1'b1;
        cpu_if.spi_status_io_load = 1'b1;
        #1 val = data_bus;
        cpu_if.spi_status_io_load = 1'b0;
        checkOutput("t5_rst_status", val, 8'h02);
        waitClocks(2);
        reset_n = 1'b1;
        waitClocks(2);
        spiSelect();
        sendFrame(8'h5A, miso_byte);
        checkOutput("t5_miso_fill", miso_byte, 8'hFF);
        spiDeselect();
        readStatus(val);  checkOutput("t5_status", val, 8'h03);
        readData(val);    checkOutput("t5_rx_buf", val, 8'h5A);
        waitClocks(3);
        checkOutput("t5_irq_idle", {7'd0, spi_irq}, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
